conv_stream_ctrl: RTL and testbench

//  Streams a raster-order image into a 3x3 sliding window and drives one conv_mat

---
 rtl/conv_pkg.sv | 17 +
 rtl/conv_mat.sv | 65 ++++++
 rtl/line_buffer.sv | 38 +++
 rtl/conv_stream_ctrl.sv | 196 +++++++++++++++++++
 tb/tb_conv_stream_ctrl.sv | 186 ++++++++++++++++++
 5 files changed

// File: rtl/conv_pkg.sv
// Shared types and window indexing for the 3x3 streaming convolution controller.
package conv_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } conv_state_e;

  localparam int WIN_N = 9;

  // Row-major index into the flattened window / kernel, r=0 is the oldest row.
  function automatic int win_idx(input int r, input int c);
    return r * 3 + c;
  endfunction

endpackage

// File: rtl/conv_mat.sv
// Combinational 3x3 multiply-accumulate with optional >>4 blur and 0..2^IMAGE_WIDTH-1 saturation.
module conv_mat #(
  parameter int    IMAGE_WIDTH     = 8,
  parameter int    KERNEL_WIDTH    = 5,
  parameter int    MATRIX_SIZE     = 3,
  parameter string ADDER_TYPE      = "RIPPLE",
  parameter string MULTIPLIER_TYPE = "ARRAY",
  localparam int   N               = MATRIX_SIZE * MATRIX_SIZE
) (
  input  logic [N*IMAGE_WIDTH-1:0]         in_matrix,
  input  logic signed [N*KERNEL_WIDTH-1:0] kernel,
  input  logic                             blur_flag,
  output logic [IMAGE_WIDTH-1:0]           out_pixel
);

  localparam int SW = IMAGE_WIDTH + KERNEL_WIDTH;
  localparam logic signed [SW-1:0] PIX_MAX = SW'((1 << IMAGE_WIDTH) - 1);

  if (MATRIX_SIZE != 3) begin : g_bad_size
    $error("conv_mat: only MATRIX_SIZE=3 is supported");
  end
  if (!(ADDER_TYPE == "RIPPLE" || ADDER_TYPE == "CLA")) begin : g_bad_adder
    $error("conv_mat: unknown ADDER_TYPE");
  end

  logic signed [SW-1:0]           pxe    [N];
  logic signed [KERNEL_WIDTH-1:0] kern_s [N];
  logic signed [SW-1:0]           prod   [N];
  logic signed [SW-1:0]           sum;
  logic signed [SW-1:0]           scaled;

  always_comb begin
    for (int i = 0; i < N; i++) begin
      pxe[i]    = SW'($signed({1'b0, in_matrix[i*IMAGE_WIDTH +: IMAGE_WIDTH]}));
      kern_s[i] = $signed(kernel[i*KERNEL_WIDTH +: KERNEL_WIDTH]);
    end
  end

  if (MULTIPLIER_TYPE == "ARRAY") begin : g_mul_array
    always_comb begin
      for (int i = 0; i < N; i++) prod[i] = pxe[i] * SW'(kern_s[i]);
    end
  end else begin : g_mul_shift_add
    // Two's-complement shift-add: the kernel MSB carries negative weight.
    always_comb begin
      for (int i = 0; i < N; i++) begin
        prod[i] = '0;
        for (int b = 0; b < KERNEL_WIDTH - 1; b++) begin
          if (kern_s[i][b]) prod[i] = prod[i] + (pxe[i] <<< b);
        end
        if (kern_s[i][KERNEL_WIDTH-1]) prod[i] = prod[i] - (pxe[i] <<< (KERNEL_WIDTH - 1));
      end
    end
  end

  always_comb begin
    sum = '0;
    for (int i = 0; i < N; i++) sum = sum + prod[i];
    scaled = blur_flag ? (sum >>> 4) : sum;
    if (scaled < 0)            out_pixel = '0;
    else if (scaled > PIX_MAX) out_pixel = '1;
    else                       out_pixel = scaled[IMAGE_WIDTH-1:0];
  end

endmodule

// File: rtl/line_buffer.sv
// Two-row pixel store indexed by column: row0 holds the previous image row, row1 the one before.
module line_buffer #(
  parameter  int IMAGE_WIDTH = 8,
  parameter  int DEPTH       = 28,
  localparam int AW          = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic                   clk,
  input  logic                   we,
  input  logic [AW-1:0]          addr,
  input  logic [IMAGE_WIDTH-1:0] wdata,
  output logic [IMAGE_WIDTH-1:0] rd0,
  output logic [IMAGE_WIDTH-1:0] rd1
);

  logic [IMAGE_WIDTH-1:0] mem0_q [DEPTH];
  logic [IMAGE_WIDTH-1:0] mem1_q [DEPTH];
  logic [IMAGE_WIDTH-1:0] mem0_d [DEPTH];
  logic [IMAGE_WIDTH-1:0] mem1_d [DEPTH];

  assign rd0 = mem0_q[addr];
  assign rd1 = mem1_q[addr];

  // A write ages the column: the old row0 value moves down to row1.
  always_comb begin
    mem0_d = mem0_q;
    mem1_d = mem1_q;
    if (we) begin
      mem1_d[addr] = mem0_q[addr];
      mem0_d[addr] = wdata;
    end
  end

  always_ff @(posedge clk) begin
    mem0_q <= mem0_d;
    mem1_q <= mem1_d;
  end

endmodule

// File: rtl/conv_stream_ctrl.sv
// Raster-order pixel stream into a 3x3 sliding window feeding conv_mat, one registered output per full window.
//
// state | meaning
// IDLE  | waiting for start; kernel/blur latched when start is seen
// RUN   | accepting pixels and emitting convolved pixels
// DONE  | last output transferred; frame_done pulse, back to IDLE
module conv_stream_ctrl
  import conv_pkg::*;
#(
  parameter int    IMAGE_WIDTH     = 8,
  parameter int    KERNEL_WIDTH    = 5,
  parameter int    MATRIX_SIZE     = 3,
  parameter int    IMG_COLS        = 28,
  parameter int    IMG_ROWS        = 28,
  parameter string ADDER_TYPE      = "RIPPLE",
  parameter string MULTIPLIER_TYPE = "ARRAY"
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      start,
  input  logic [KERNEL_WIDTH*9-1:0] kernel_in,
  input  logic                      blur_in,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [IMAGE_WIDTH-1:0]    in_pixel,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [IMAGE_WIDTH-1:0]    out_pixel,
  output logic                      out_last,
  output logic                      busy,
  output logic                      frame_done
);

  localparam int CW = (IMG_COLS > 1) ? $clog2(IMG_COLS) : 1;
  localparam int RW = (IMG_ROWS > 1) ? $clog2(IMG_ROWS) : 1;

  if (MATRIX_SIZE != 3) begin : g_bad_size
    $error("conv_stream_ctrl: only MATRIX_SIZE=3 is supported");
  end
  if (IMG_COLS < 3 || IMG_ROWS < 3) begin : g_bad_dims
    $error("conv_stream_ctrl: image must be at least 3x3");
  end

  conv_state_e               state_q, state_d;
  logic [CW-1:0]             col_q, col_d;
  logic [RW-1:0]             row_q, row_d;
  logic                      input_done_q, input_done_d;
  logic [KERNEL_WIDTH*9-1:0] kernel_q, kernel_d;
  logic                      blur_q, blur_d;
  logic                      out_valid_q, out_valid_d;
  logic                      out_last_q, out_last_d;
  logic [IMAGE_WIDTH-1:0]    out_pixel_q, out_pixel_d;
  logic [IMAGE_WIDTH-1:0]    win_q  [WIN_N];
  logic [IMAGE_WIDTH-1:0]    win_d  [WIN_N];
  logic [IMAGE_WIDTH-1:0]    win_sh [WIN_N];

  logic [IMAGE_WIDTH-1:0]       lb0_rd, lb1_rd;
  logic [WIN_N*IMAGE_WIDTH-1:0] conv_in;
  logic [IMAGE_WIDTH-1:0]       conv_pixel;
  logic                         in_xfer, out_xfer, emit, at_last_col, at_last_row;

  assign in_ready    = (state_q == RUN) && !input_done_q && (!out_valid_q || out_ready);
  assign in_xfer     = in_valid && in_ready;
  assign out_xfer    = out_valid_q && out_ready;
  assign at_last_col = (col_q == CW'(IMG_COLS - 1));
  assign at_last_row = (row_q == RW'(IMG_ROWS - 1));
  assign emit        = in_xfer && (row_q >= RW'(2)) && (col_q >= CW'(2));

  assign out_valid  = out_valid_q;
  assign out_last   = out_last_q;
  assign out_pixel  = out_pixel_q;
  assign busy       = (state_q != IDLE);
  assign frame_done = (state_q == DONE);

  line_buffer #(
    .IMAGE_WIDTH (IMAGE_WIDTH),
    .DEPTH       (IMG_COLS)
  ) u_lb (
    .clk   (clk),
    .we    (in_xfer),
    .addr  (col_q),
    .wdata (in_pixel),
    .rd0   (lb0_rd),
    .rd1   (lb1_rd)
  );

  // conv_mat always sees the post-shift window, so the result is ready on the accepting edge.
  always_comb begin
    for (int i = 0; i < WIN_N; i++) win_sh[i] = win_q[i];
    for (int r = 0; r < 3; r++) begin
      for (int c = 0; c < 2; c++) win_sh[win_idx(r, c)] = win_q[win_idx(r, c + 1)];
    end
    win_sh[win_idx(0, 2)] = lb1_rd;
    win_sh[win_idx(1, 2)] = lb0_rd;
    win_sh[win_idx(2, 2)] = in_pixel;
    conv_in = '0;
    for (int i = 0; i < WIN_N; i++) begin
      conv_in[i*IMAGE_WIDTH +: IMAGE_WIDTH] = win_sh[i];
      win_d[i] = in_xfer ? win_sh[i] : win_q[i];
    end
  end

  conv_mat #(
    .IMAGE_WIDTH     (IMAGE_WIDTH),
    .KERNEL_WIDTH    (KERNEL_WIDTH),
    .MATRIX_SIZE     (MATRIX_SIZE),
    .ADDER_TYPE      (ADDER_TYPE),
    .MULTIPLIER_TYPE (MULTIPLIER_TYPE)
  ) u_conv (
    .in_matrix (conv_in),
    .kernel    (kernel_q),
    .blur_flag (blur_q),
    .out_pixel (conv_pixel)
  );

  always_comb begin
    state_d      = state_q;
    col_d        = col_q;
    row_d        = row_q;
    input_done_d = input_done_q;
    kernel_d     = kernel_q;
    blur_d       = blur_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d      = RUN;
          kernel_d     = kernel_in;
          blur_d       = blur_in;
          col_d        = '0;
          row_d        = '0;
          input_done_d = 1'b0;
        end
      end
      RUN: begin
        if (in_xfer) begin
          if (at_last_col) begin
            col_d = '0;
            if (at_last_row) input_done_d = 1'b1;
            else             row_d = row_q + RW'(1);
          end else begin
            col_d = col_q + CW'(1);
          end
        end
        if (out_xfer && out_last_q) state_d = DONE;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // A new emit on the same edge as a transfer replaces the outgoing pixel.
  always_comb begin
    out_valid_d = out_valid_q;
    out_last_d  = out_last_q;
    out_pixel_d = out_pixel_q;
    if (out_xfer) begin
      out_valid_d = 1'b0;
      out_last_d  = 1'b0;
    end
    if (emit) begin
      out_valid_d = 1'b1;
      out_pixel_d = conv_pixel;
      out_last_d  = at_last_row && at_last_col;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      col_q        <= '0;
      row_q        <= '0;
      input_done_q <= 1'b0;
      kernel_q     <= '0;
      blur_q       <= 1'b0;
      out_valid_q  <= 1'b0;
      out_last_q   <= 1'b0;
      out_pixel_q  <= '0;
    end else begin
      state_q      <= state_d;
      col_q        <= col_d;
      row_q        <= row_d;
      input_done_q <= input_done_d;
      kernel_q     <= kernel_d;
      blur_q       <= blur_d;
      out_valid_q  <= out_valid_d;
      out_last_q   <= out_last_d;
      out_pixel_q  <= out_pixel_d;
    end
  end

  // Window contents are masked by the counters and need no reset.
  always_ff @(posedge clk) begin
    win_q <= win_d;
  end

endmodule

// File: tb/tb_conv_stream_ctrl.sv
// Directed frame-level bench for conv_stream_ctrl using a 4x4 and a 5x5 instance.
module tb_conv_stream_ctrl;

  logic        clk = 1'b0;
  logic        rst, start, blur_in, in_valid, out_ready, sel;
  logic [7:0]  in_pixel;
  logic [44:0] kernel_in;
  logic        start4, start5;

  logic       in_ready4, out_valid4, out_last4, busy4, frame_done4;
  logic       in_ready5, out_valid5, out_last5, busy5, frame_done5;
  logic [7:0] out_pixel4, out_pixel5;
  logic       in_ready_m, out_valid_m, out_last_m, busy_m, frame_done_m;
  logic [7:0] out_pixel_m;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  assign start4       = start && !sel;
  assign start5       = start && sel;
  assign in_ready_m   = sel ? in_ready5   : in_ready4;
  assign out_valid_m  = sel ? out_valid5  : out_valid4;
  assign out_last_m   = sel ? out_last5   : out_last4;
  assign out_pixel_m  = sel ? out_pixel5  : out_pixel4;
  assign busy_m       = sel ? busy5       : busy4;
  assign frame_done_m = sel ? frame_done5 : frame_done4;

  conv_stream_ctrl #(.IMG_COLS(4), .IMG_ROWS(4)) dut4 (
    .clk(clk), .rst(rst), .start(start4), .kernel_in(kernel_in), .blur_in(blur_in),
    .in_valid(in_valid), .in_ready(in_ready4), .in_pixel(in_pixel),
    .out_valid(out_valid4), .out_ready(out_ready), .out_pixel(out_pixel4),
    .out_last(out_last4), .busy(busy4), .frame_done(frame_done4)
  );

  conv_stream_ctrl #(.IMG_COLS(5), .IMG_ROWS(5)) dut5 (
    .clk(clk), .rst(rst), .start(start5), .kernel_in(kernel_in), .blur_in(blur_in),
    .in_valid(in_valid), .in_ready(in_ready5), .in_pixel(in_pixel),
    .out_valid(out_valid5), .out_ready(out_ready), .out_pixel(out_pixel5),
    .out_last(out_last5), .busy(busy5), .frame_done(frame_done5)
  );

  typedef struct {
    logic        sel;       // 0: 4x4 instance, 1: 5x5 instance
    logic        ramp;      // pixel = raster index instead of constant
    logic [7:0]  pix;
    logic [44:0] kern;
    logic        blur;
    int          exp;       // expected constant output (ramp frames use the centre-pixel formula)
    int          stall_at;  // cycle at which out_ready drops for 5 cycles, 0 = never
  } frame_t;

  frame_t tbl[6];

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic logic [44:0] kfill(input int v);
    logic [44:0] k;
    for (int i = 0; i < 9; i++) k[i*5 +: 5] = 5'(v);
    return k;
  endfunction

  function automatic logic [44:0] kpack(input int a, input int b, input int c, input int d,
                                        input int e, input int f, input int g, input int h,
                                        input int j);
    logic [44:0] k;
    k = {5'(j), 5'(h), 5'(g), 5'(f), 5'(e), 5'(d), 5'(c), 5'(b), 5'(a)};
    return k;
  endfunction

  task automatic check_idle_outputs(input string tag);
    check({tag, "_busy"},       int'(busy_m), 0);
    check({tag, "_out_valid"},  int'(out_valid_m), 0);
    check({tag, "_out_last"},   int'(out_last_m), 0);
    check({tag, "_out_pixel"},  int'(out_pixel_m), 0);
    check({tag, "_frame_done"}, int'(frame_done_m), 0);
    check({tag, "_in_ready"},   int'(in_ready_m), 0);
  endtask

  task automatic run_frame(input frame_t f);
    int n, npix, nout, pi, oi, cyc, expv;
    logic       hold;
    logic [7:0] hold_pix;
    n    = f.sel ? 5 : 4;
    npix = n * n;
    nout = (n - 2) * (n - 2);
    pi = 0; oi = 0; cyc = 0; hold = 1'b0; hold_pix = '0;
    @(negedge clk);
    sel = f.sel; start = 1'b1; kernel_in = f.kern; blur_in = f.blur;
    in_valid = 1'b0; out_ready = 1'b1;
    @(negedge clk);
    // Changing kernel/blur after the accepted start must not affect the frame.
    start = 1'b0; kernel_in = ~f.kern; blur_in = ~f.blur;
    check("busy_after_start", int'(busy_m), 1);
    while (oi < nout && cyc < 1000) begin
      in_valid  = (pi < npix);
      in_pixel  = f.ramp ? 8'(pi) : f.pix;
      out_ready = !(f.stall_at > 0 && cyc >= f.stall_at && cyc < f.stall_at + 5);
      start     = (cyc == 3);
      #1;
      if (hold) begin
        check("stall_valid_held", int'(out_valid_m), 1);
        check("stall_pixel_stable", int'(out_pixel_m), int'(hold_pix));
      end
      if (out_valid_m && !out_ready) begin
        check("stall_in_ready_low", int'(in_ready_m), 0);
        hold = 1'b1;
        hold_pix = out_pixel_m;
      end else begin
        hold = 1'b0;
      end
      if (out_valid_m && out_ready) begin
        expv = f.ramp ? ((oi / (n - 2)) + 1) * n + (oi % (n - 2)) + 1 : f.exp;
        check("out_pixel", int'(out_pixel_m), expv);
        check("out_last", int'(out_last_m), int'(oi == nout - 1));
        oi++;
      end
      if (in_valid && in_ready_m) pi++;
      cyc++;
      @(negedge clk);
    end
    in_valid = 1'b0; start = 1'b0; out_ready = 1'b1;
    check("frame_output_count", oi, nout);
    check("frame_input_count", pi, npix);
    check("frame_done_pulse", int'(frame_done_m), 1);
    check("busy_in_done", int'(busy_m), 1);
    @(negedge clk);
    check("frame_done_cleared", int'(frame_done_m), 0);
    check("busy_back_idle", int'(busy_m), 0);
    check("out_valid_after_frame", int'(out_valid_m), 0);
  endtask

  initial begin
    logic [44:0] k_ident, k_smooth;
    frame_t f;
    k_ident  = kpack(0, 0, 0, 0, 1, 0, 0, 0, 0);
    k_smooth = kpack(1, 2, 1, 2, 4, 2, 1, 2, 1);
    tbl[0] = '{1'b0, 1'b0, 8'd10,  kfill(1),  1'b0, 90,  0};
    tbl[1] = '{1'b1, 1'b1, 8'd0,   k_ident,   1'b0, 0,   0};
    tbl[2] = '{1'b0, 1'b0, 8'd100, k_smooth,  1'b1, 100, 0};
    tbl[3] = '{1'b0, 1'b0, 8'd255, k_smooth,  1'b0, 255, 0};
    tbl[4] = '{1'b0, 1'b0, 8'd50,  kfill(-1), 1'b0, 0,   0};
    tbl[5] = '{1'b1, 1'b1, 8'd0,   k_ident,   1'b0, 0,   14};

    rst = 1'b1; start = 1'b0; blur_in = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    sel = 1'b0; in_pixel = '0; kernel_in = '0;
    repeat (3) @(posedge clk);
    #1;
    check_idle_outputs("reset4");
    sel = 1'b1;
    #1;
    check_idle_outputs("reset5");
    @(negedge clk);
    rst = 1'b0;

    for (int t = 0; t < 6; t++) run_frame(tbl[t]);

    // Reset with a pending output mid-frame, then a clean frame with a new kernel.
    @(negedge clk);
    sel = 1'b0; start = 1'b1; kernel_in = kfill(1); blur_in = 1'b0;
    @(negedge clk);
    start = 1'b0; in_pixel = 8'd10; in_valid = 1'b1; out_ready = 1'b0;
    repeat (12) @(negedge clk);
    check("pre_reset_pending", int'(out_valid_m), 1);
    check("pre_reset_pixel", int'(out_pixel_m), 90);
    rst = 1'b1; in_valid = 1'b0;
    @(posedge clk);
    #1;
    check_idle_outputs("midframe_reset");
    @(negedge clk);
    rst = 1'b0; out_ready = 1'b1;
    f = '{1'b0, 1'b0, 8'd10, kfill(2), 1'b1, 11, 0};
    run_frame(f);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
